// File: rtl/mult_div_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// One bit per cycle on a shared (WIDTH+1)-bit adder: shift-add multiply, restoring divide.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               op_div, op_signed;
  logic [WIDTH-1:0]   a_raw, b_raw, opnd;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic               neg_res, neg_rem, div_zero;
  logic               idle_like, accept;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_x, add_y, add_sum;
  logic [WIDTH-1:0]   hi_res, lo_res;

  assign op_div    = op_q[1];
  assign op_signed = op_q[0];
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign accept    = idle_like && start;

  assign sign_a = op_signed & a_raw[WIDTH-1];
  assign sign_b = op_signed & b_raw[WIDTH-1];
  assign abs_a  = sign_a ? -a_raw : a_raw;
  assign abs_b  = sign_b ? -b_raw : b_raw;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_PREP;
      S_PREP: begin
        busy       = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == '0) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = start ? S_PREP : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Divide: {rem,quo} shifted left feeds rem-divisor as x + ~d + 1.
  // Multiply: upper half plus multiplicand when the low accumulator bit is set.
  always_comb begin
    add_x   = op_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = op_div ? ~{1'b0, opnd} : (acc[0] ? {1'b0, opnd} : '0);
    add_sum = add_x + add_y + (WIDTH+1)'(op_div);
    if (!op_div)
      acc_step = {add_sum, acc[WIDTH-1:1]};
    else if (!add_sum[WIDTH])
      acc_step = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        lo_res = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before being consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op;
      a_raw <= src_a;
      b_raw <= src_b;
    end
    if (state == S_PREP) begin
      opnd     <= op_div ? abs_b : abs_a;
      acc      <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= op_div && (b_raw == '0);
    end else if (state == S_RUN) begin
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      if (state == S_PREP)
        count <= CW'(WIDTH - 1);
      else if (state == S_RUN)
        count <= count - CW'(1);
      // A start in IDLE/DONE takes priority over a same-cycle MTHI/MTLO.
      if (state == S_FIX) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (idle_like && !start) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: arithmetic results, latency, HI/LO writes,
// ignored requests while busy, back-to-back start and mid-operation reset.
module tb_mult_div_seq;

  localparam int W = 32;
  localparam int LAT = 34;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic seen_done;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge, then scrambles the operand inputs.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op    = 2'($urandom);
  endtask

  task automatic wait_done(input int already, output int l);
    l = already;
    while (!done && l < 100) begin
      step();
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int l;
    launch(o, a, b);
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(0, l);
    check({tag, " latency"}, 64'(l), 64'(LAT));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    step();
    step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    step();

    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    step();
    check("done width", 64'(done), 64'd0);
    check("idle busy", 64'(busy), 64'd0);

    run_op("mult -3*7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    run_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    step();
    step();

    // Start and MTHI while the multiply is running must both be ignored.
    launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) step();
    check("mid run busy", 64'(busy), 64'd1);
    op    = DIVU;
    src_a = 32'd1;
    src_b = 32'd1;
    wdata = 32'h5555_5555;
    start = 1'b1;
    mthi  = 1'b1;
    step();
    start = 1'b0;
    mthi  = 1'b0;
    check("ignored mthi hi", 64'(hi), 64'h0);
    wait_done(6, lat);
    check("ignored start latency", 64'(lat), 64'(LAT));
    check("ignored start hi", 64'(hi), 64'hFFFF_FFFE);
    check("ignored start lo", 64'(lo), 64'h0000_0001);
    step();
    step();

    wdata = 32'h0000_1234;
    mtlo  = 1'b1;
    step();
    mtlo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h1234);
    check("mtlo hi kept", 64'(hi), 64'hFFFF_FFFE);
    wdata = 32'hA5A5_A5A5;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    step();
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthi+mtlo hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthi+mtlo lo", 64'(lo), 64'hA5A5_A5A5);

    // Back-to-back: new request issued in the DONE cycle.
    run_op("b2b first", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    check("b2b in done", 64'(done), 64'd1);
    launch(DIVU, 32'd100, 32'd7);
    check("b2b busy", 64'(busy), 64'd1);
    check("b2b done low", 64'(done), 64'd0);
    check("b2b hi held", 64'(hi), 64'hFFFF_FFFF);
    wait_done(0, lat);
    check("b2b latency", 64'(lat), 64'(LAT));
    check("b2b hi", 64'(hi), 64'd2);
    check("b2b lo", 64'(lo), 64'd14);

    // Reset in the middle of RUN abandons the operation.
    launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen_done = seen_done | done;
    end
    check("midrst no done", 64'(seen_done), 64'd0);
    check("midrst lo later", 64'(lo), 64'd0);

    // Start with a same-cycle MTHI: the write is dropped.
    op    = DIVU;
    src_a = 32'd9;
    src_b = 32'd3;
    wdata = 32'h0000_DEAD;
    start = 1'b1;
    mthi  = 1'b1;
    step();
    start = 1'b0;
    mthi  = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    check("start+mthi busy", 64'(busy), 64'd1);
    check("start+mthi hi", 64'(hi), 64'd0);
    wait_done(0, lat);
    check("divu 9/3 latency", 64'(lat), 64'(LAT));
    check("divu 9/3 hi", 64'(hi), 64'd0);
    check("divu 9/3 lo", 64'(lo), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
